ethernet_rx_frame_controller: RTL and testbench



---
 rtl/ethernet_rx_frame_controller.sv | 208 ++++++++++++++++++++
 tb/tb_ethernet_rx_frame_controller.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_rx_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_rx_frame_controller
// Description : MII receive sequencer. Strips preamble/SFD, gates payload
//               nibbles to the nibble-to-byte aggregator (padding odd-length
//               frames), and frames the stream with start/end/error strobes
//               and a running byte count.
//               Optional macro ETH_RX_STATS_EN adds good/bad frame counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ethernet_rx_frame_controller #(
  parameter int MIN_PREAMBLE_NIBBLES = 8,
  parameter int MAX_FRAME_BYTES      = 1522,
  parameter int COUNT_WIDTH          = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_dv,
  input  logic                   rx_er,
  input  logic [3:0]             rxd,
  output logic [3:0]             nibble,
  output logic                   nibble_ready,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   frame_error,
  output logic [1:0]             error_code,
  output logic [COUNT_WIDTH-1:0] byte_count,
  output logic                   busy
`ifdef ETH_RX_STATS_EN
  ,
  output logic [15:0]            good_frames,
  output logic [15:0]            bad_frames
`endif
);

  localparam int PRE_W = (MIN_PREAMBLE_NIBBLES >= 1) ? $clog2(MIN_PREAMBLE_NIBBLES + 1) : 1;
  localparam logic [PRE_W-1:0]       PRE_SAT   = PRE_W'(MIN_PREAMBLE_NIBBLES);
  localparam logic [COUNT_WIDTH-1:0] MAX_BYTES = COUNT_WIDTH'(MAX_FRAME_BYTES);

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_RXER  = 2'd1;
  localparam logic [1:0] CODE_ALIGN = 2'd2;
  localparam logic [1:0] CODE_LONG  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_DROP     = 3'd4
  } state_t;

  state_t                   state, state_n;
  logic [PRE_W-1:0]         pre_cnt, pre_cnt_n;
  logic                     parity, parity_n;
  logic [1:0]               pend_code, pend_code_n;
  logic [3:0]               nibble_n;
  logic                     nibble_ready_n, frame_start_n, frame_end_n, frame_error_n;
  logic [1:0]               error_code_n;
  logic [COUNT_WIDTH-1:0]   byte_count_n;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n        = state;
    pre_cnt_n      = pre_cnt;
    parity_n       = parity;
    pend_code_n    = pend_code;
    byte_count_n   = byte_count;
    error_code_n   = error_code;
    nibble_n       = 4'h0;
    nibble_ready_n = 1'b0;
    frame_start_n  = 1'b0;
    frame_end_n    = 1'b0;
    frame_error_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (rx_dv) begin
          if (rxd == 4'h5) begin
            state_n   = ST_PREAMBLE;
            pre_cnt_n = PRE_W'(1);
          end else begin
            state_n = ST_DROP;            // false carrier
          end
        end
      end

      ST_PREAMBLE: begin
        if (!rx_dv) begin
          state_n = ST_IDLE;
        end else if (rx_er) begin
          state_n = ST_DROP;
        end else if (rxd == 4'h5) begin
          if (pre_cnt != PRE_SAT) pre_cnt_n = pre_cnt + PRE_W'(1);
        end else if (rxd == 4'hD && pre_cnt >= PRE_SAT) begin
          state_n      = ST_DATA;
          byte_count_n = '0;
          parity_n     = 1'b0;
          error_code_n = CODE_NONE;
        end else begin
          state_n = ST_DROP;
        end
      end

      ST_DATA: begin
        if (!rx_dv) begin
          if (parity) begin
            // Odd nibble count: pad the aggregator, report after the pad.
            state_n        = ST_FLUSH;
            pend_code_n    = CODE_ALIGN;
            nibble_ready_n = 1'b1;
          end else if (byte_count == '0) begin
            state_n = ST_IDLE;            // empty frame, no strobes
          end else begin
            state_n       = ST_IDLE;
            frame_end_n   = 1'b1;
            error_code_n  = CODE_NONE;
          end
        end else if (rx_er) begin
          if (parity) begin
            state_n        = ST_FLUSH;
            pend_code_n    = CODE_RXER;
            nibble_ready_n = 1'b1;
          end else begin
            state_n       = ST_DROP;
            frame_end_n   = 1'b1;
            frame_error_n = 1'b1;
            error_code_n  = CODE_RXER;
          end
        end else if (!parity && byte_count == MAX_BYTES) begin
          state_n       = ST_DROP;
          frame_end_n   = 1'b1;
          frame_error_n = 1'b1;
          error_code_n  = CODE_LONG;
        end else begin
          nibble_n       = rxd;
          nibble_ready_n = 1'b1;
          frame_start_n  = !parity && (byte_count == '0);
          parity_n       = ~parity;
          if (parity) byte_count_n = byte_count + COUNT_WIDTH'(1);
        end
      end

      ST_FLUSH: begin
        frame_end_n   = 1'b1;
        frame_error_n = (pend_code != CODE_NONE);
        error_code_n  = pend_code;
        parity_n      = 1'b0;
        state_n       = (pend_code != CODE_ALIGN && rx_dv) ? ST_DROP : ST_IDLE;
      end

      ST_DROP: begin
        if (!rx_dv) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      pre_cnt      <= '0;
      parity       <= 1'b0;
      pend_code    <= CODE_NONE;
      nibble       <= 4'h0;
      nibble_ready <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      frame_error  <= 1'b0;
      error_code   <= CODE_NONE;
      byte_count   <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      pre_cnt      <= pre_cnt_n;
      parity       <= parity_n;
      pend_code    <= pend_code_n;
      nibble       <= nibble_n;
      nibble_ready <= nibble_ready_n;
      frame_start  <= frame_start_n;
      frame_end    <= frame_end_n;
      frame_error  <= frame_error_n;
      error_code   <= error_code_n;
      byte_count   <= byte_count_n;
      busy         <= (state_n != ST_IDLE);
    end
  end

`ifdef ETH_RX_STATS_EN
  // Saturating good/bad frame counters, bumped alongside each frame_end.
  always_ff @(posedge clk) begin
    if (reset) begin
      good_frames <= 16'h0;
      bad_frames  <= 16'h0;
    end else if (frame_end_n) begin
      if (frame_error_n) begin
        if (bad_frames != 16'hFFFF) bad_frames <= bad_frames + 16'h1;
      end else begin
        if (good_frames != 16'hFFFF) good_frames <= good_frames + 16'h1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ethernet_rx_frame_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ethernet_rx_frame_controller
// Description : Self-checking bench: directed scenarios plus random frames
//               compared against a rule-level frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ethernet_rx_frame_controller;

  localparam int MIN_PRE   = 8;
  localparam int MAX_BYTES = 4;
  localparam int CW        = 11;

  logic          clk = 1'b0;
  logic          reset, rx_dv, rx_er;
  logic [3:0]    rxd;
  logic [3:0]    nibble;
  logic          nibble_ready, frame_start, frame_end, frame_error, busy;
  logic [1:0]    error_code;
  logic [CW-1:0] byte_count;
`ifdef ETH_RX_STATS_EN
  logic [15:0]   good_frames, bad_frames;
`endif

  int errors = 0;
  int checks = 0;
  int exp_good = 0;
  int exp_bad  = 0;
  int last_bc  = 0;

  always #5 clk = ~clk;

  ethernet_rx_frame_controller #(
    .MIN_PREAMBLE_NIBBLES(MIN_PRE),
    .MAX_FRAME_BYTES(MAX_BYTES),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .nibble(nibble), .nibble_ready(nibble_ready), .frame_start(frame_start),
    .frame_end(frame_end), .frame_error(frame_error), .error_code(error_code),
    .byte_count(byte_count), .busy(busy)
`ifdef ETH_RX_STATS_EN
    , .good_frames(good_frames), .bad_frames(bad_frames)
`endif
  );

  // Output monitor: records every strobe event on the falling edge.
  logic [3:0]    got_nib[$];
  logic [1:0]    got_code[$];
  logic          got_err[$];
  logic [CW-1:0] got_bc[$];
  int            got_starts = 0;

  always @(negedge clk) begin
    if (nibble_ready) got_nib.push_back(nibble);
    if (frame_start) got_starts++;
    if (frame_end) begin
      got_code.push_back(error_code);
      got_err.push_back(frame_error);
      got_bc.push_back(byte_count);
    end
  end

  task automatic clear_mon();
    got_nib.delete(); got_code.delete(); got_err.delete(); got_bc.delete();
    got_starts = 0;
  endtask

  // One MII cycle: inputs change just after the falling edge.
  task automatic step(input logic dv, input logic er, input logic [3:0] d);
    @(negedge clk);
    #1;
    rx_dv = dv; rx_er = er; rxd = d;
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'hD);
  endtask

  // ---------------- reference model ----------------
  // Stimulus of one frame (rx_dv high on every entry), and its expectations.
  logic [3:0] stim_d[$];
  bit         stim_e[$];
  logic [3:0] exp_nib[$];
  bit         exp_acc, exp_end, exp_start;
  int         exp_code, exp_bc;

  task automatic model_frame();
    int k;
    int fwd;
    bit ended;
    k = 0; fwd = 0; ended = 0;
    exp_nib.delete();
    exp_acc = 0; exp_end = 0; exp_start = 0; exp_code = 0; exp_bc = 0;
    if (stim_d.size() == 0 || stim_d[0] != 4'h5) return;
    while (k < stim_d.size() && stim_d[k] == 4'h5 && !stim_e[k]) k++;
    if (k >= stim_d.size() || stim_d[k] != 4'hD || stim_e[k] || k < MIN_PRE) return;
    exp_acc = 1;
    for (int i = k + 1; i < stim_d.size(); i++) begin
      if (stim_e[i]) begin exp_code = 1; ended = 1; break; end
      if (fwd == 2 * MAX_BYTES) begin exp_code = 3; ended = 1; break; end
      exp_nib.push_back(stim_d[i]);
      fwd++;
    end
    if (!ended) exp_code = (fwd % 2) ? 2 : 0;
    exp_end   = ended || (fwd > 0);
    exp_start = (fwd > 0);
    if (exp_end && (fwd % 2)) exp_nib.push_back(4'h0);
    exp_bc = fwd / 2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'h5);
    checks++;
    if ({nibble, nibble_ready, frame_start} !== 6'h0) begin
      errors++; $display("FAIL reset_nibble: got %h expected 0", {nibble, nibble_ready, frame_start});
    end
    checks++;
    if ({frame_end, frame_error, error_code} !== 4'h0) begin
      errors++; $display("FAIL reset_end: got %h expected 0", {frame_end, frame_error, error_code});
    end
    checks++;
    if (byte_count !== '0) begin
      errors++; $display("FAIL reset_byte_count: got %0d expected 0", byte_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    reset = 1'b0;
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_good_even();
    preamble(15);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL even_busy: got %b expected 1", busy); end
    step(1'b1, 1'b0, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    checks++;
    if ({nibble_ready, nibble, frame_start} !== {1'b1, 4'h1, 1'b1}) begin
      errors++; $display("FAIL even_first: got %h expected %h", {nibble_ready, nibble, frame_start}, {1'b1, 4'h1, 1'b1});
    end
    step(1'b1, 1'b0, 4'h3);
    checks++;
    if ({nibble_ready, nibble, frame_start} !== {1'b1, 4'h2, 1'b0}) begin
      errors++; $display("FAIL even_second: got %h expected %h", {nibble_ready, nibble, frame_start}, {1'b1, 4'h2, 1'b0});
    end
    step(1'b1, 1'b0, 4'h4);
    checks++;
    if ({nibble_ready, nibble} !== {1'b1, 4'h3}) begin
      errors++; $display("FAIL even_third: got %h expected %h", {nibble_ready, nibble}, {1'b1, 4'h3});
    end
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if ({nibble_ready, nibble, frame_end, byte_count} !== {1'b1, 4'h4, 1'b0, 11'd2}) begin
      errors++; $display("FAIL even_fourth: got %h expected %h", {nibble_ready, nibble, frame_end, byte_count}, {1'b1, 4'h4, 1'b0, 11'd2});
    end
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if ({frame_end, frame_error, error_code, byte_count, nibble_ready} !== {1'b1, 1'b0, 2'd0, 11'd2, 1'b0}) begin
      errors++; $display("FAIL even_end: got %h expected %h", {frame_end, frame_error, error_code, byte_count, nibble_ready}, {1'b1, 1'b0, 2'd0, 11'd2, 1'b0});
    end
    exp_good++;
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if ({frame_end, busy} !== 2'b00) begin
      errors++; $display("FAIL even_idle: got %b expected 00", {frame_end, busy});
    end
  endtask

  task automatic test_odd_pad();
    preamble(15);
    step(1'b1, 1'b0, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h3);
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if ({nibble_ready, nibble, byte_count} !== {1'b1, 4'h3, 11'd1}) begin
      errors++; $display("FAIL odd_last: got %h expected %h", {nibble_ready, nibble, byte_count}, {1'b1, 4'h3, 11'd1});
    end
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if ({nibble_ready, nibble, frame_end} !== {1'b1, 4'h0, 1'b0}) begin
      errors++; $display("FAIL odd_pad: got %h expected %h", {nibble_ready, nibble, frame_end}, {1'b1, 4'h0, 1'b0});
    end
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if ({frame_end, frame_error, error_code, byte_count, nibble_ready} !== {1'b1, 1'b1, 2'd2, 11'd1, 1'b0}) begin
      errors++; $display("FAIL odd_end: got %h expected %h", {frame_end, frame_error, error_code, byte_count, nibble_ready}, {1'b1, 1'b1, 2'd2, 11'd1, 1'b0});
    end
    exp_bad++;
    step(1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_rx_er();
    preamble(15);
    step(1'b1, 1'b0, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b1, 4'h3);
    checks++;
    if ({nibble_ready, nibble} !== {1'b1, 4'h2}) begin
      errors++; $display("FAIL rxer_nib2: got %h expected %h", {nibble_ready, nibble}, {1'b1, 4'h2});
    end
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b0, 4'h7);
      if (j == 0) begin
        checks++;
        if ({nibble_ready, frame_end, frame_error, error_code, byte_count, busy} !== {1'b0, 1'b1, 1'b1, 2'd1, 11'd1, 1'b1}) begin
          errors++; $display("FAIL rxer_end: got %h expected %h", {nibble_ready, frame_end, frame_error, error_code, byte_count, busy}, {1'b0, 1'b1, 1'b1, 2'd1, 11'd1, 1'b1});
        end
      end else if (j == 1) begin
        checks++;
        if ({nibble_ready, frame_end, busy} !== 3'b001) begin
          errors++; $display("FAIL rxer_nopad: got %b expected 001", {nibble_ready, frame_end, busy});
        end
      end
    end
    exp_bad++;
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rxer_busy_hold: got %b expected 1", busy); end
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rxer_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_short_preamble();
    clear_mon();
    preamble(3);
    for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 4'(j + 1));
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL short_busy: got %b expected 1", busy); end
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if ({got_nib.size(), got_code.size(), got_starts, 32'(busy)} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL short_silent: nibbles=%0d ends=%0d starts=%0d busy=%b expected all 0",
                         got_nib.size(), got_code.size(), got_starts, busy);
    end
    checks++;
    if (byte_count !== 11'd1) begin errors++; $display("FAIL short_bc_hold: got %0d expected 1", byte_count); end
  endtask

  task automatic test_too_long();
    clear_mon();
    preamble(15);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 4'(i + 1));
      if (i == 9) begin
        checks++;
        if ({frame_end, error_code, byte_count, nibble_ready} !== {1'b1, 2'd3, 11'd4, 1'b0}) begin
          errors++; $display("FAIL long_end: got %h expected %h", {frame_end, error_code, byte_count, nibble_ready}, {1'b1, 2'd3, 11'd4, 1'b0});
        end
      end
    end
    exp_bad++;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0);
    checks++;
    if (got_nib.size() != 8 || got_code.size() != 1) begin
      errors++; $display("FAIL long_counts: nibbles=%0d ends=%0d expected 8 and 1", got_nib.size(), got_code.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_nib[i] !== 4'(i + 1)) begin
          errors++; $display("FAIL long_nib%0d: got %h expected %h", i, got_nib[i], 4'(i + 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] v;
    preamble(15);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'(i + 9));
    @(negedge clk); #1;
    reset = 1'b1; rx_dv = 1'b1; rxd = 4'hE;
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if ({nibble, nibble_ready, frame_start, frame_end, frame_error, error_code, byte_count, busy} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %h expected 0",
                         {nibble, nibble_ready, frame_start, frame_end, frame_error, error_code, byte_count, busy});
    end
    reset = 1'b0;
    exp_good = 0; exp_bad = 0;
    step(1'b0, 1'b0, 4'h0);
    clear_mon();
    stim_d.delete(); stim_e.delete();
    for (int i = 0; i < 15; i++) begin stim_d.push_back(4'h5); stim_e.push_back(1'b0); end
    stim_d.push_back(4'hD); stim_e.push_back(1'b0);
    for (int i = 0; i < 6; i++) begin
      v = 4'($urandom_range(0, 15));
      stim_d.push_back(v); stim_e.push_back(1'b0);
    end
    model_frame();
    for (int i = 0; i < stim_d.size(); i++) step(1'b1, stim_e[i], stim_d[i]);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0);
    exp_good++;
    last_bc = 3;
    checks++;
    if (got_nib.size() != 6 || got_code.size() != 1) begin
      errors++; $display("FAIL midreset_counts: nibbles=%0d ends=%0d expected 6 and 1", got_nib.size(), got_code.size());
    end else begin
      checks++;
      if (got_nib != exp_nib) begin
        errors++; $display("FAIL midreset_stream: got %p expected %p", got_nib, exp_nib);
      end
      checks++;
      if ({got_code[0], got_err[0], got_bc[0]} !== {2'd0, 1'b0, 11'd3}) begin
        errors++; $display("FAIL midreset_end: got %h expected %h", {got_code[0], got_err[0], got_bc[0]}, {2'd0, 1'b0, 11'd3});
      end
    end
`ifdef ETH_RX_STATS_EN
    checks++;
    if ({good_frames, bad_frames} !== {16'd1, 16'd0}) begin
      errors++; $display("FAIL midreset_stats: good=%0d bad=%0d expected 1 and 0", good_frames, bad_frames);
    end
`endif
  endtask

  task automatic test_random();
    int pre, plen, erp;
    logic [3:0] v, sfd;
    for (int f = 0; f < 60; f++) begin
      stim_d.delete(); stim_e.delete();
      case ($urandom_range(0, 7))
        0:       pre = 0;
        1:       pre = $urandom_range(1, 9);
        default: pre = $urandom_range(8, 16);
      endcase
      if (pre == 0) begin
        v = 4'($urandom_range(0, 15));
        stim_d.push_back(v); stim_e.push_back(1'b0);
      end
      for (int i = 0; i < pre; i++) begin stim_d.push_back(4'h5); stim_e.push_back(1'b0); end
      sfd = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'hD;
      stim_d.push_back(sfd); stim_e.push_back(1'b0);
      plen = $urandom_range(0, 12);
      erp  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, plen) : -1;
      for (int i = 0; i < plen; i++) begin
        v = 4'($urandom_range(0, 15));
        stim_d.push_back(v); stim_e.push_back(i == erp);
      end
      model_frame();
      clear_mon();
      for (int i = 0; i < stim_d.size(); i++) step(1'b1, stim_e[i], stim_d[i]);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0);
      if (exp_end) begin
        if (exp_code == 0) exp_good++; else exp_bad++;
      end
      if (exp_acc) last_bc = exp_bc;

      checks++;
      if (got_nib != exp_nib) begin
        errors++; $display("FAIL rand%0d_stream: got %p expected %p", f, got_nib, exp_nib);
      end
      checks++;
      if (got_starts != int'(exp_start)) begin
        errors++; $display("FAIL rand%0d_start: got %0d expected %0d", f, got_starts, exp_start);
      end
      checks++;
      if (got_code.size() != int'(exp_end)) begin
        errors++; $display("FAIL rand%0d_ends: got %0d expected %0d", f, got_code.size(), exp_end);
      end else if (exp_end) begin
        checks++;
        if ({got_code[0], got_err[0], got_bc[0]} !== {2'(exp_code), exp_code != 0, CW'(exp_bc)}) begin
          errors++; $display("FAIL rand%0d_end: got code=%0d err=%b bc=%0d expected code=%0d err=%b bc=%0d",
                             f, got_code[0], got_err[0], got_bc[0], exp_code, exp_code != 0, exp_bc);
        end
      end
      checks++;
      if ({byte_count, busy} !== {CW'(last_bc), 1'b0}) begin
        errors++; $display("FAIL rand%0d_hold: got bc=%0d busy=%b expected bc=%0d busy=0", f, byte_count, busy, last_bc);
      end
    end
`ifdef ETH_RX_STATS_EN
    checks++;
    if ({good_frames, bad_frames} !== {16'(exp_good), 16'(exp_bad)}) begin
      errors++; $display("FAIL rand_stats: good=%0d bad=%0d expected %0d and %0d", good_frames, bad_frames, exp_good, exp_bad);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rxd = 4'h0;
    test_reset();
    test_good_even();
    test_odd_pad();
    test_rx_er();
    test_short_preamble();
    test_too_long();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
